// File: rtl/hdlc_tx_frame_ctrl.sv
// HDLC transmit frame sequencer: flags, zero insertion, CRC-16 FCS, idle ones and abort.
// The state register describes the bit currently on Tx; the next bit is chosen combinationally and registered.
module hdlc_tx_frame_ctrl #(
    parameter int MAX_BYTES = 126
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tx_Enable,
    input  logic       Tx_AbortFrame,
    input  logic [7:0] Tx_FrameSize,
    input  logic [7:0] Tx_Data,
    output logic       Tx_RdBuff,
    output logic       Tx,
    output logic       Tx_ValidFrame,
    output logic       Tx_Done,
    output logic       Tx_AbortedTrans,
    output logic       Tx_SizeErr
);

    typedef enum logic [2:0] {IDLE, START_FLAG, DATA, FCS, END_FLAG, ABORT} state_t;

    localparam logic [7:0] FLAG      = 8'h7E;
    localparam logic [7:0] ABORT_PAT = 8'hFE;
    localparam logic [7:0] MAX_SIZE  = 8'(MAX_BYTES);

    state_t      state, stateNext;
    logic [2:0]  cnt, cntNext;
    logic [7:0]  shReg, shNext;
    logic [3:0]  bitsLeft, bitsLeftNext;
    logic [7:0]  byteIdx, byteIdxNext;
    logic [7:0]  frameSize, frameSizeNext;
    logic [7:0]  holdReg;
    logic        rdPend;
    logic [15:0] crc, crcNext, crcUpd;
    logic [2:0]  onesCnt, onesNext;
    logic        txNext, doneNext, abortedNext, sizeErrNext;
    logic        serialise, rdBuff;

    // Serial CRC-16 (reflected 0xA001) step for the bit at the head of the shift register.
    assign crcUpd = (crc >> 1) ^ ((crc[0] ^ shReg[0]) ? 16'hA001 : 16'h0000);

    assign Tx_RdBuff     = rdBuff;
    assign Tx_ValidFrame = (state == START_FLAG) || (state == DATA) ||
                           (state == FCS) || (state == END_FLAG);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        stateNext     = state;
        cntNext       = cnt;
        shNext        = shReg;
        bitsLeftNext  = bitsLeft;
        byteIdxNext   = byteIdx;
        frameSizeNext = frameSize;
        crcNext       = crc;
        onesNext      = onesCnt;
        txNext        = 1'b1;
        doneNext      = 1'b0;
        abortedNext   = 1'b0;
        sizeErrNext   = 1'b0;
        serialise     = 1'b0;
        rdBuff        = 1'b0;

        case (state)
            IDLE: begin
                if (Tx_Enable) begin
                    if (Tx_FrameSize != 8'd0 && Tx_FrameSize <= MAX_SIZE) begin
                        stateNext     = START_FLAG;
                        cntNext       = 3'd0;
                        txNext        = FLAG[0];
                        onesNext      = 3'd0;
                        crcNext       = 16'h0000;
                        bitsLeftNext  = 4'd0;
                        byteIdxNext   = 8'd0;
                        frameSizeNext = Tx_FrameSize;
                    end else begin
                        sizeErrNext = 1'b1;
                    end
                end
            end
            START_FLAG: begin
                rdBuff  = (cnt == 3'd0);
                cntNext = cnt + 3'd1;
                txNext  = FLAG[cnt + 3'd1];
                // Byte 0 has landed in the hold register by now; move it to the shifter.
                if (cnt == 3'd6) begin
                    shNext       = holdReg;
                    bitsLeftNext = 4'd8;
                    byteIdxNext  = 8'd1;
                    rdBuff       = (frameSize > 8'd1);
                end
                if (cnt == 3'd7)
                    serialise = 1'b1;
            end
            DATA, FCS: serialise = 1'b1;
            END_FLAG: begin
                cntNext = cnt + 3'd1;
                txNext  = FLAG[cnt + 3'd1];
                if (cnt == 3'd7) begin
                    stateNext = IDLE;
                    txNext    = 1'b1;
                    doneNext  = 1'b1;
                end
            end
            ABORT: begin
                cntNext = cnt + 3'd1;
                txNext  = ABORT_PAT[cnt + 3'd1];
                if (cnt == 3'd7) begin
                    stateNext   = IDLE;
                    txNext      = 1'b1;
                    abortedNext = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase

        if (serialise) begin
            if (onesCnt == 3'd5) begin
                txNext    = 1'b0;
                onesNext  = 3'd0;
                stateNext = (state == FCS) ? FCS : DATA;
            end else if (bitsLeft == 4'd0) begin
                stateNext = END_FLAG;
                cntNext   = 3'd0;
                txNext    = FLAG[0];
            end else begin
                txNext       = shReg[0];
                onesNext     = shReg[0] ? onesCnt + 3'd1 : 3'd0;
                stateNext    = (byteIdx > frameSize) ? FCS : DATA;
                shNext       = shReg >> 1;
                bitsLeftNext = bitsLeft - 4'd1;
                if (byteIdx <= frameSize)
                    crcNext = crcUpd;
                // Reload on the last bit: next payload byte, then CRC low, then CRC high.
                if (bitsLeft == 4'd1) begin
                    if (byteIdx < frameSize) begin
                        shNext       = holdReg;
                        bitsLeftNext = 4'd8;
                        byteIdxNext  = byteIdx + 8'd1;
                        rdBuff       = (byteIdx + 8'd1 < frameSize);
                    end else if (byteIdx == frameSize) begin
                        shNext       = crcUpd[7:0];
                        bitsLeftNext = 4'd8;
                        byteIdxNext  = byteIdx + 8'd1;
                    end else if (byteIdx == frameSize + 8'd1) begin
                        shNext       = crc[15:8];
                        bitsLeftNext = 4'd8;
                        byteIdxNext  = byteIdx + 8'd1;
                    end
                end
            end
        end

        if (Tx_AbortFrame && Tx_ValidFrame) begin
            stateNext = ABORT;
            cntNext   = 3'd0;
            txNext    = ABORT_PAT[0];
            doneNext  = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (Rst) begin
            state           <= IDLE;
            cnt             <= 3'd0;
            shReg           <= 8'd0;
            bitsLeft        <= 4'd0;
            byteIdx         <= 8'd0;
            frameSize       <= 8'd0;
            holdReg         <= 8'd0;
            rdPend          <= 1'b0;
            crc             <= 16'h0000;
            onesCnt         <= 3'd0;
            Tx              <= 1'b1;
            Tx_Done         <= 1'b0;
            Tx_AbortedTrans <= 1'b0;
            Tx_SizeErr      <= 1'b0;
        end else begin
            state           <= stateNext;
            cnt             <= cntNext;
            shReg           <= shNext;
            bitsLeft        <= bitsLeftNext;
            byteIdx         <= byteIdxNext;
            frameSize       <= frameSizeNext;
            holdReg         <= rdPend ? Tx_Data : holdReg;
            rdPend          <= rdBuff;
            crc             <= crcNext;
            onesCnt         <= onesNext;
            Tx              <= txNext;
            Tx_Done         <= doneNext;
            Tx_AbortedTrans <= abortedNext;
            Tx_SizeErr      <= sizeErrNext;
        end
    end

endmodule

// File: tb/tb_hdlc_tx_frame_ctrl.sv
// Directed bench for hdlc_tx_frame_ctrl: captures the serial line, destuffs it and
// compares against hand-computed bit streams, CRC values and handshake counts.
module tb_hdlc_tx_frame_ctrl;

    logic       Clk = 1'b0;
    logic       Rst, Tx_Enable, Tx_AbortFrame;
    logic [7:0] Tx_FrameSize, Tx_Data;
    logic       Tx_RdBuff, Tx, Tx_ValidFrame, Tx_Done, Tx_AbortedTrans, Tx_SizeErr;

    hdlc_tx_frame_ctrl #(.MAX_BYTES(126)) dut (
        .Clk(Clk), .Rst(Rst), .Tx_Enable(Tx_Enable), .Tx_AbortFrame(Tx_AbortFrame),
        .Tx_FrameSize(Tx_FrameSize), .Tx_Data(Tx_Data), .Tx_RdBuff(Tx_RdBuff), .Tx(Tx),
        .Tx_ValidFrame(Tx_ValidFrame), .Tx_Done(Tx_Done), .Tx_AbortedTrans(Tx_AbortedTrans),
        .Tx_SizeErr(Tx_SizeErr)
    );

    always #5 Clk = ~Clk;

    int         nChecks = 0;
    int         nFails  = 0;
    logic [7:0] mem [0:127];
    bit         txBits[$];
    bit         abortBits[$];
    logic [7:0] dec[$];
    int         rdCount, rdInAbort, doneSeen, abortSeen, validRuns;
    bit         doneAfterValid, endTx, timedOut;
    logic [0:7] flagSeq = 8'b01111110;

    // Starts a frame of n bytes from mem[] and records the line until Done/AbortedTrans.
    task automatic run_frame(input int n, input bit startAbort, input int abortAt);
        int ptr = 0;
        bit prevValid = 0;
        txBits.delete(); abortBits.delete();
        rdCount = 0; rdInAbort = 0; doneSeen = 0; abortSeen = 0; validRuns = 0;
        doneAfterValid = 0; endTx = 0; timedOut = 1;
        @(negedge Clk);
        Tx_Enable = 1; Tx_FrameSize = 8'(n); Tx_AbortFrame = startAbort;
        @(negedge Clk);
        Tx_Enable = 0; Tx_AbortFrame = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (Tx_ValidFrame && !prevValid) validRuns++;
            if (Tx_ValidFrame) txBits.push_back(Tx);
            else if (validRuns > 0 && !Tx_Done && !Tx_AbortedTrans) abortBits.push_back(Tx);
            if (Tx_RdBuff) begin
                rdCount++;
                if (!Tx_ValidFrame) rdInAbort++;
                Tx_Data = mem[ptr];
                ptr++;
            end
            if (Tx_Done) begin doneSeen++; doneAfterValid = prevValid; end
            if (Tx_AbortedTrans) abortSeen++;
            Tx_AbortFrame = (abortAt >= 0 && Tx_ValidFrame && txBits.size() == abortAt + 1);
            prevValid = Tx_ValidFrame;
            if (Tx_Done || Tx_AbortedTrans) begin
                endTx = Tx;
                timedOut = 0;
                break;
            end
            @(negedge Clk);
        end
        Tx_AbortFrame = 0;
        nChecks++;
        if (timedOut) begin nFails++; $display("FAIL frame_timeout: no Done/AbortedTrans within 3000 cycles (n=%0d)", n); end
    endtask

    function automatic bit flags_ok();
        int n = txBits.size();
        if (n < 16) return 0;
        for (int i = 0; i < 8; i++)
            if (txBits[i] !== flagSeq[i] || txBits[n-8+i] !== flagSeq[i]) return 0;
        return 1;
    endfunction

    // Removes stuffed zeros between the flags and packs LSB-first bytes into dec[].
    task automatic decode_body();
        int ones = 0;
        int nb = 0;
        logic [7:0] cur = 8'h00;
        dec.delete();
        for (int i = 8; i < txBits.size() - 8; i++) begin
            if (ones == 5) begin ones = 0; continue; end
            cur[nb] = txBits[i];
            nb++;
            if (nb == 8) begin dec.push_back(cur); nb = 0; end
            ones = txBits[i] ? ones + 1 : 0;
        end
    endtask

    task automatic check_frame_end(input string name);
        nChecks++;
        if (doneSeen !== 1 || doneAfterValid !== 1'b1 || endTx !== 1'b1 || abortSeen !== 0) begin
            nFails++;
            $display("FAIL %s_done: done=%0d afterValid=%0b tx=%0b aborted=%0d, want 1/1/1/0",
                     name, doneSeen, doneAfterValid, endTx, abortSeen);
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        Rst = 1; Tx_Enable = 0; Tx_AbortFrame = 0; Tx_FrameSize = 0; Tx_Data = 0;
        repeat (2) @(negedge Clk);
        Rst = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if ({Tx, Tx_RdBuff, Tx_ValidFrame, Tx_Done, Tx_AbortedTrans, Tx_SizeErr} !== 6'b100000) bad++;
        end
        nChecks++;
        if (bad != 0) begin nFails++; $display("FAIL reset_idle: %0d bad idle cycles, want 0", bad); end
    endtask

    task automatic test_zero_byte(input string name, input bit startAbort);
        logic [0:39] e = 40'b01111110_00000000_0000000000000000_01111110;
        int bad = 0;
        mem[0] = 8'h00;
        run_frame(1, startAbort, -1);
        for (int i = 0; i < txBits.size() && i < 40; i++) if (txBits[i] !== e[i]) bad++;
        nChecks++;
        if (txBits.size() != 40 || bad != 0) begin
            nFails++; $display("FAIL %s_bits: %0d cycles %0d wrong bits, want 40 cycles 0 wrong", name, txBits.size(), bad);
        end
        nChecks++;
        if (rdCount != 1) begin nFails++; $display("FAIL %s_rdbuff: %0d pulses, want 1", name, rdCount); end
        check_frame_end(name);
    endtask

    task automatic test_ones_byte();
        logic [0:40] e = 41'b01111110_111110111_00000010_00000010_01111110;
        int bad = 0;
        mem[0] = 8'hFF;
        run_frame(1, 0, -1);
        for (int i = 0; i < txBits.size() && i < 41; i++) if (txBits[i] !== e[i]) bad++;
        nChecks++;
        if (txBits.size() != 41 || bad != 0) begin
            nFails++; $display("FAIL ones_bits: %0d cycles %0d wrong bits, want 41 cycles 0 wrong", txBits.size(), bad);
        end
        check_frame_end("ones");
    endtask

    task automatic test_check_value();
        int bad = 0;
        for (int i = 0; i < 9; i++) mem[i] = 8'h31 + 8'(i);
        run_frame(9, 0, -1);
        nChecks++;
        if (validRuns != 1 || !flags_ok()) begin
            nFails++; $display("FAIL crc_framing: validRuns=%0d flags_ok=%0b, want 1/1", validRuns, flags_ok());
        end
        decode_body();
        if (dec.size() == 11) for (int i = 0; i < 9; i++) if (dec[i] !== mem[i]) bad++;
        nChecks++;
        if (dec.size() != 11 || bad != 0) begin
            nFails++; $display("FAIL crc_payload: %0d bytes %0d wrong, want 11 bytes 0 wrong", dec.size(), bad);
        end
        nChecks++;
        if (dec.size() != 11 || {dec[10], dec[9]} !== 16'hBB3D) begin
            nFails++; $display("FAIL crc_fcs: got %h%h, want bb3d", dec.size() > 10 ? dec[10] : 8'hxx, dec.size() > 9 ? dec[9] : 8'hxx);
        end
        nChecks++;
        if (rdCount != 9) begin nFails++; $display("FAIL crc_rdbuff: %0d pulses, want 9", rdCount); end
        check_frame_end("crc");
    endtask

    task automatic test_max_size();
        int bad = 0;
        for (int i = 0; i < 126; i++) mem[i] = 8'(i * 37 + 5);
        run_frame(126, 0, -1);
        decode_body();
        if (dec.size() == 128) for (int i = 0; i < 126; i++) if (dec[i] !== mem[i]) bad++;
        nChecks++;
        if (!flags_ok() || dec.size() != 128 || bad != 0 || rdCount != 126) begin
            nFails++; $display("FAIL max_size: bytes=%0d wrong=%0d rd=%0d flags=%0b, want 128/0/126/1",
                               dec.size(), bad, rdCount, flags_ok());
        end
        check_frame_end("max");
    endtask

    task automatic test_abort();
        logic [0:7] e = 8'b01111111;
        int bad = 0;
        for (int i = 0; i < 4; i++) mem[i] = 8'hA5 ^ 8'(i);
        run_frame(4, 0, 10);
        for (int i = 0; i < abortBits.size() && i < 8; i++) if (abortBits[i] !== e[i]) bad++;
        nChecks++;
        if (txBits.size() != 11 || abortBits.size() != 8 || bad != 0) begin
            nFails++; $display("FAIL abort_bits: valid=%0d abort=%0d wrong=%0d, want 11/8/0", txBits.size(), abortBits.size(), bad);
        end
        nChecks++;
        if (abortSeen != 1 || doneSeen != 0 || endTx !== 1'b1 || rdInAbort != 0) begin
            nFails++; $display("FAIL abort_status: aborted=%0d done=%0d tx=%0b rdInAbort=%0d, want 1/0/1/0",
                               abortSeen, doneSeen, endTx, rdInAbort);
        end
    endtask

    task automatic test_size_err();
        logic [7:0] sizes [2];
        int bad = 0;
        sizes[0] = 8'd0; sizes[1] = 8'd127;
        for (int k = 0; k < 2; k++) begin
            @(negedge Clk);
            Tx_Enable = 1; Tx_FrameSize = sizes[k];
            @(negedge Clk);
            Tx_Enable = 0;
            nChecks++;
            if (Tx_SizeErr !== 1'b1 || Tx !== 1'b1 || Tx_ValidFrame !== 1'b0) begin
                nFails++; $display("FAIL size_err_%0d: err=%0b tx=%0b valid=%0b, want 1/1/0", sizes[k], Tx_SizeErr, Tx, Tx_ValidFrame);
            end
            @(negedge Clk);
            nChecks++;
            if (Tx_SizeErr !== 1'b0 || Tx !== 1'b1 || Tx_ValidFrame !== 1'b0) begin
                nFails++; $display("FAIL size_err_pulse_%0d: err=%0b tx=%0b, want 0/1", sizes[k], Tx_SizeErr, Tx);
            end
        end
        Tx_AbortFrame = 1;
        @(negedge Clk);
        Tx_AbortFrame = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (Tx !== 1'b1 || Tx_AbortedTrans !== 1'b0 || Tx_ValidFrame !== 1'b0) bad++;
        end
        nChecks++;
        if (bad != 0) begin nFails++; $display("FAIL idle_abort: %0d bad cycles, want 0", bad); end
    endtask

    task automatic test_reset_mid();
        int ptr = 0;
        for (int i = 0; i < 4; i++) mem[i] = 8'h3C + 8'(i);
        @(negedge Clk);
        Tx_Enable = 1; Tx_FrameSize = 8'd4;
        @(negedge Clk);
        Tx_Enable = 0;
        for (int i = 0; i < 12; i++) begin
            if (Tx_RdBuff) begin Tx_Data = mem[ptr]; ptr++; end
            @(negedge Clk);
        end
        nChecks++;
        if (Tx_ValidFrame !== 1'b1) begin nFails++; $display("FAIL reset_mid_pre: valid=%0b, want 1", Tx_ValidFrame); end
        Rst = 1;
        @(negedge Clk);
        nChecks++;
        if (Tx !== 1'b1 || Tx_ValidFrame !== 1'b0 || Tx_RdBuff !== 1'b0) begin
            nFails++; $display("FAIL reset_mid: tx=%0b valid=%0b rd=%0b, want 1/0/0", Tx, Tx_ValidFrame, Tx_RdBuff);
        end
        Rst = 0;
    endtask

    initial begin
        test_reset();
        test_zero_byte("zero", 0);
        test_ones_byte();
        test_check_value();
        test_abort();
        test_size_err();
        test_zero_byte("start_abort", 1);
        test_reset_mid();
        test_zero_byte("after_reset", 0);
        test_max_size();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/hdlc_tx_frame_ctrl.md
Name: hdlc_tx_frame_ctrl

Overview:
Transmit-side frame sequencer for the HDLC controller. It fetches bytes from the Tx buffer through a read-strobe handshake and serialises them one bit per clock onto Tx. It wraps each frame in start/end flags, performs zero insertion, and appends a CRC-16 FCS. It also drives idle ones between frames and the abort pattern on request, and reports completion and abort to the status/control register.

Parameters:
MAX_BYTES, 126, largest accepted frame payload in bytes (FCS excluded)

Ports:
Clk  in  1  system clock; all logic on rising edge
Rst  in  1  synchronous reset, active-high
Tx_Enable  in  1  start request, one-cycle pulse, sampled in IDLE only
Tx_AbortFrame  in  1  abort request, one-cycle pulse
Tx_FrameSize  in  8  payload byte count, sampled with Tx_Enable
Tx_Data  in  8  buffer read data, valid the cycle after Tx_RdBuff
Tx_RdBuff  out  1  buffer read strobe, one-cycle pulse per byte
Tx  out  1  serial line, registered, LSB-first
Tx_ValidFrame  out  1  high from first start-flag bit to last end-flag bit
Tx_Done  out  1  one-cycle pulse after last end-flag bit
Tx_AbortedTrans  out  1  one-cycle pulse after last abort-pattern bit
Tx_SizeErr  out  1  one-cycle pulse when a start is rejected

Behaviour:
- Reset (Rst=1 at an edge): state=IDLE; Tx=1; all other outputs 0; CRC, ones counter, byte counter and shift/hold registers cleared. Reset mid-frame truncates the frame; no abort pattern is sent.
- FSM states: IDLE, START_FLAG, DATA, FCS, END_FLAG, ABORT.
- IDLE: Tx=1 continuously.
  - Tx_Enable with 1<=Tx_FrameSize<=MAX_BYTES -> START_FLAG; first flag bit appears on Tx after the next edge (1-cycle latency).
  - Tx_FrameSize=0 or >MAX_BYTES -> Tx_SizeErr pulse, stay IDLE.
  - Tx_AbortFrame in IDLE is ignored.
- START_FLAG: 8 cycles emitting 0,1,1,1,1,1,1,0. Tx_RdBuff pulses in its first cycle, prefetching byte 0. -> DATA.
- DATA:
  - Shift register loaded from the hold register; bits sent LSB first.
  - On each load, Tx_RdBuff pulses to prefetch the next byte, except after the last byte. Tx_Data is captured one cycle later.
  - After Tx_FrameSize bytes -> FCS.
- Zero insertion (DATA and FCS only):
  - Ones counter counts consecutive transmitted 1s.
  - After five 1s, the next cycle emits a stuffed 0 and the shift register stalls.
  - The counter clears on any transmitted 0, including stuffed bits, and at START_FLAG entry.
  - The counter carries across byte boundaries and across the DATA->FCS boundary.
- CRC-16: polynomial 0x8005, reflected form (0xA001), init 0x0000, no final XOR, LSB-first update. Updated on payload data bits only; stuffed bits and flags are excluded. Check value: "123456789" -> 0xBB3D.
- FCS: 16 bits, low CRC byte first, LSB first, stuffed as data -> END_FLAG.
- END_FLAG: 8 cycles 01111110; Tx_ValidFrame drops after its last bit. Tx_Done pulses in the cycle after, together with the return to IDLE (Tx=1).
- Frame length in cycles: 8 + 8*N + 16 + stuffed bits + 8.
- Abort:
  - Tx_AbortFrame in START_FLAG, DATA, FCS or END_FLAG -> ABORT at the next edge, discarding the current bit position.
  - ABORT: 8 cycles emitting 0,1,1,1,1,1,1,1 (zero first); Tx_ValidFrame=0; no further Tx_RdBuff.
  - Tx_AbortedTrans pulses in the cycle after the last abort bit, with the return to IDLE; Tx_Done is not asserted.
  - Tx_AbortFrame during ABORT is ignored.
- Tx_Enable while not in IDLE: ignored, no Tx_SizeErr.
- Simultaneous Tx_Enable and Tx_AbortFrame in IDLE: the frame starts and the abort is ignored.
- Simultaneous Tx_AbortFrame and the final END_FLAG bit: abort wins; Tx_Done is not asserted.

Test Plan:
- Reset, then idle 20 cycles -> Tx=1 throughout; all outputs 0.
- FrameSize=1, byte 0x00 -> Tx=01111110, 00000000, sixteen 0s (CRC 0x0000), 01111110. Exactly 2 Tx_RdBuff pulses are not allowed: exactly one. Tx_Done 1 cycle after the last flag bit. Total 40 frame cycles.
- FrameSize=1, byte 0xFF -> data bits 11111 0 111 (stuff after the fifth 1); FCS 0x4040 sent 00000010 00000010; then end flag; 41 frame cycles.
- FrameSize=9, bytes "123456789" -> FCS bits decode to 0xBB3D; 9 Tx_RdBuff pulses; Tx_ValidFrame high for the whole frame.
- Tx_AbortFrame in the 3rd DATA cycle -> next 8 Tx bits 01111111; Tx_AbortedTrans pulse; no Tx_Done; Tx=1 afterwards.
- Tx_FrameSize=0 and then 127 with Tx_Enable -> Tx_SizeErr pulse each time; Tx stays 1. Rst=1 mid-DATA -> Tx=1 and Tx_ValidFrame=0 at the next edge.
